// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin scheduler that time-shares one external
// combinational ALU among NREQ requesters. Each granted operation takes
// one EXEC cycle and one RESP cycle; divide-by-zero is intercepted here
// because the ALU cannot handle it.
module alu_share_sched #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NREQ-1:0]                   req,
    input  logic [NREQ*(WIDTH/2)-1:0]         req_a,
    input  logic [NREQ*(WIDTH/2)-1:0]         req_b,
    input  logic [NREQ*$clog2(WIDTH)-1:0]     req_op,
    output logic [NREQ-1:0]                   gnt,
    output logic [NREQ-1:0]                   done,
    output logic [WIDTH-1:0]                  result,
    output logic                              err,
    output logic                              busy,
    output logic [WIDTH/2-1:0]                alu_a,
    output logic [WIDTH/2-1:0]                alu_b,
    output logic [$clog2(WIDTH)-1:0]          alu_opcode,
    input  logic [WIDTH-1:0]                  alu_y
);

    localparam int HW  = WIDTH / 2;
    localparam int OPW = $clog2(WIDTH);
    localparam int PW  = $clog2(NREQ);

    localparam logic [OPW-1:0] OP_DIV = OPW'(3);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_idx;
    logic            win_valid;
    logic            div_zero;

    // Requester index ptr+k, wrapped modulo NREQ (NREQ need not be a power of 2).
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int k);
        return PW'((int'(p) + k) % NREQ);
    endfunction

    // Round-robin pick: first pending request scanning upward from ptr+1.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // so no path leaves it unassigned and no latch is inferred.
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_valid && req[wrap_idx(ptr, k)]) begin
                win_valid = 1'b1;
                win_idx   = wrap_idx(ptr, k);
            end
        end
    end

    // The ALU is bypassed when a divide sees a zero divisor.
    assign div_zero = (alu_opcode == OP_DIV) && (alu_b == '0);

    assign busy = (state != IDLE);

    // FSM next-state: IDLE waits for a request, EXEC and RESP last one cycle each.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Datapath: latch winner operands at grant, capture result after EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= PW'(NREQ - 1);
            gnt        <= '0;
            done       <= '0;
            result     <= '0;
            err        <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        alu_a      <= req_a[win_idx*HW +: HW];
                        alu_b      <= req_b[win_idx*HW +: HW];
                        alu_opcode <= req_op[win_idx*OPW +: OPW];
                        gnt        <= NREQ'(1) << win_idx;
                        ptr        <= win_idx;
                    end
                end
                EXEC: begin
                    done <= gnt;
                    gnt  <= '0;
                    if (div_zero) begin
                        result <= '1;
                        err    <= 1'b1;
                    end else begin
                        result <= alu_y;
                        err    <= 1'b0;
                    end
                end
                RESP: begin
                    done <= '0;
                    err  <= 1'b0;
                end
                default: begin
                    gnt  <= '0;
                    done <= '0;
                    err  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_sched.sv
// Testbench for alu_share_sched: behavioural ALU model on the alu_* ports,
// a table of single-operation vectors, and hand-written multi-cycle cases.
module tb_alu_share_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [11:0] req_op;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  result;
    logic        err;
    logic        busy;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_y;

    int n_tests = 0;
    int n_fail  = 0;

    alu_share_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .gnt        (gnt),
        .done       (done),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_y      (alu_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU model: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor, 7 concat.
    always_comb begin
        logic [7:0] xa;
        logic [7:0] xb;
        xa = {4'h0, alu_a};
        xb = {4'h0, alu_b};
        alu_y = 8'h00;
        case (alu_opcode)
            3'd0: alu_y = xa + xb;
            3'd1: alu_y = xa - xb;
            3'd2: alu_y = xa * xb;
            3'd3: alu_y = (xb == 8'h00) ? 8'h00 : xa / xb;
            3'd4: alu_y = xa & xb;
            3'd5: alu_y = xa | xb;
            3'd6: alu_y = xa ^ xb;
            default: alu_y = {alu_a, alu_b};
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Structural invariants, sampled mid-cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            check("done_onehot0", 32'($onehot0(done)), 32'd1);
            check("gnt_done_excl", 32'(gnt & done), 32'd0);
        end
    end

    typedef struct {
        bit          do_rst;
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [11:0] op;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_res;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    // One operation from IDLE: grant next edge, done/result the edge after.
    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        @(negedge clk);
        if (v.do_rst) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        req    = v.req;
        req_a  = v.a;
        req_b  = v.b;
        req_op = v.op;
        @(posedge clk); #1;
        check({tag, "_gnt"}, 32'(gnt), 32'(v.exp_gnt));
        check({tag, "_busy_exec"}, 32'(busy), 32'd1);
        check({tag, "_done_exec"}, 32'(done), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done"}, 32'(done), 32'(v.exp_gnt));
        check({tag, "_result"}, 32'(result), 32'(v.exp_res));
        check({tag, "_err"}, 32'(err), 32'(v.exp_err));
        check({tag, "_busy_resp"}, 32'(busy), 32'd1);
        check({tag, "_gnt_resp"}, 32'(gnt), 32'd0);
        req = req & ~v.exp_gnt;
        @(posedge clk); #1;
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_result_hold"}, 32'(result), 32'(v.exp_res));
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        req_a  = '0;
        req_b  = '0;
        req_op = '0;

        //        rst   req      a         b         op        gnt      res    err
        vecs[0]  = '{1'b1, 4'b0001, 16'h0003, 16'h0004, 12'o0000, 4'b0001, 8'h07, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 16'h4321, 16'h2222, 12'o2222, 4'b0001, 8'h02, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 16'h4321, 16'h2222, 12'o2222, 4'b0010, 8'h04, 1'b0};
        vecs[3]  = '{1'b0, 4'b1111, 16'h4321, 16'h2222, 12'o2222, 4'b0100, 8'h06, 1'b0};
        vecs[4]  = '{1'b0, 4'b1111, 16'h4321, 16'h2222, 12'o2222, 4'b1000, 8'h08, 1'b0};
        vecs[5]  = '{1'b0, 4'b1111, 16'h4321, 16'h2222, 12'o2222, 4'b0001, 8'h02, 1'b0};
        vecs[6]  = '{1'b0, 4'b0100, 16'h0900, 16'h0000, 12'o0300, 4'b0100, 8'hFF, 1'b1};
        vecs[7]  = '{1'b0, 4'b0100, 16'h0900, 16'h0200, 12'o0300, 4'b0100, 8'h04, 1'b0};
        vecs[8]  = '{1'b0, 4'b1001, 16'h500C, 16'h700A, 12'o1004, 4'b1000, 8'hFE, 1'b0};
        vecs[9]  = '{1'b0, 4'b1001, 16'h500C, 16'h700A, 12'o1004, 4'b0001, 8'h08, 1'b0};
        vecs[10] = '{1'b0, 4'b0110, 16'h0F30, 16'h0F50, 12'o0260, 4'b0010, 8'h06, 1'b0};
        vecs[11] = '{1'b0, 4'b0110, 16'h0F30, 16'h0F50, 12'o0260, 4'b0100, 8'hE1, 1'b0};

        // Reset state.
        #3;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_opcode), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);
        @(negedge clk);
        req = '0;

        // Operands latched at grant: req_a changes during EXEC are ignored.
        @(negedge clk);
        req    = 4'b0010;
        req_a  = 16'h00A0;
        req_b  = 16'h0050;
        req_op = 12'o0070;
        @(posedge clk); #1;
        check("latch_gnt", 32'(gnt), 32'b0010);
        req_a = 16'h0000;
        @(posedge clk); #1;
        check("latch_done", 32'(done), 32'b0010);
        check("latch_result", 32'(result), 32'hA5);
        req = '0;
        @(posedge clk); #1;

        // Reset during EXEC aborts; a held request is regranted afterwards.
        @(negedge clk);
        req    = 4'b1000;
        req_a  = 16'h1000;
        req_b  = 16'h2000;
        req_op = 12'o0000;
        @(posedge clk); #1;
        check("abort_gnt", 32'(gnt), 32'b1000);
        #1 rst = 1'b1;
        #1;
        check("abort_gnt_clr", 32'(gnt), 32'd0);
        check("abort_done_clr", 32'(done), 32'd0);
        check("abort_result_clr", 32'(result), 32'd0);
        check("abort_busy_clr", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("regrant_gnt", 32'(gnt), 32'b1000);
        @(posedge clk); #1;
        check("regrant_done", 32'(done), 32'b1000);
        check("regrant_result", 32'(result), 32'h03);
        req = '0;
        @(posedge clk); #1;

        // Request dropped during EXEC still completes, with no second grant.
        @(negedge clk);
        req    = 4'b0001;
        req_a  = 16'h0002;
        req_b  = 16'h0002;
        req_op = 12'o0000;
        @(posedge clk); #1;
        check("drop_gnt", 32'(gnt), 32'b0001);
        req = '0;
        @(posedge clk); #1;
        check("drop_done", 32'(done), 32'b0001);
        check("drop_result", 32'(result), 32'h04);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("drop_no_regrant", 32'(gnt), 32'd0);
            check("drop_idle", 32'(busy), 32'd0);
            check("drop_no_done", 32'(done), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_sched.md
Name: alu_share_sched

Overview:
- Round-robin scheduler that shares one combinational `alu` instance among NREQ requesters.
- Per-requester flow:
  - Arbitrates among pending requests.
  - Latches the winner's operands and opcode, then drives the shared ALU.
  - Captures the ALU result and returns it with a one-cycle done pulse.
  - Guards divide-by-zero, which the ALU cannot handle.
- Sits between client blocks and the ALU. The ALU ports connect directly to `alu_a`/`alu_b`/`alu_opcode`/`alu_y`.

Parameters:
- WIDTH, 8: ALU result width. Operands are WIDTH/2 bits; opcode is $clog2(WIDTH) bits.
- NREQ, 4: number of requesters, range 2..8.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req, input, NREQ: request per requester. Held high until the matching done pulse.
- req_a, input, NREQ*WIDTH/2: operand A per requester; requester i occupies slice i.
- req_b, input, NREQ*WIDTH/2: operand B per requester.
- req_op, input, NREQ*$clog2(WIDTH): opcode per requester.
- gnt, output, NREQ: one-hot grant, high while the operation executes.
- done, output, NREQ: one-hot, one-cycle pulse; result and err are valid in that cycle.
- result, output, WIDTH: registered ALU result.
- err, output, 1: high with done when the operation was divide (op==3) with B==0.
- busy, output, 1: high in any state other than IDLE.
- alu_a, output, WIDTH/2: operand A to the shared ALU.
- alu_b, output, WIDTH/2: operand B to the shared ALU.
- alu_opcode, output, $clog2(WIDTH): opcode to the shared ALU.
- alu_y, input, WIDTH: result from the shared ALU.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; the round-robin pointer points at requester NREQ-1, so requester 0 has first priority.
  - gnt, done, result, err, busy, alu_a, alu_b, alu_opcode all 0.
- Reset mid-operation aborts the operation: no done is issued, and the requester must re-request.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req bit is high at a clock edge, select the winner: first set bit scanning from ptr+1 upward, wrapping modulo NREQ.
  - At that edge, register the winner's operands and opcode into alu_a/alu_b/alu_opcode, set gnt = onehot(winner), set ptr = winner, go to EXEC.
  - Operands are sampled only at this edge. Later changes on req_a/req_b/req_op have no effect.
- EXEC (exactly one cycle):
  - alu_* are stable; the ALU settles combinationally.
  - At the next edge: result <= alu_y; done <= onehot(winner); gnt <= 0; go to RESP.
  - If alu_opcode==3 and alu_b==0: result <= all ones and err <= 1; alu_y is ignored. Otherwise err <= 0.
- RESP (one cycle):
  - done and err are high; result is valid.
  - The requester drops req in this cycle.
  - At the next edge: done <= 0, err <= 0, go to IDLE.
  - result holds its value until the next capture.
- Latency:
  - Req sampled at edge t → gnt during [t, t+1] → done/result during [t+1, t+2].
  - Next arbitration at edge t+3 at the earliest.
  - Minimum issue interval is 3 cycles.
- req is not sampled in EXEC or RESP. A req dropped during EXEC does not cancel the operation; done is still pulsed.
- A req still high in the cycle after RESP is treated as a new request and takes part in arbitration normally.
- Simultaneous requests: exactly one grant. Rotation is fair, so a continuously requesting client waits at most NREQ-1 operations.
- Width rules:
  - The scheduler does no arithmetic on the operands.
  - result is the full WIDTH bits of alu_y, unmodified except for the divide-by-zero case.
- Invariants:
  - gnt is zero or one-hot; done is zero or one-hot; gnt and done are never high together.
  - busy = (state != IDLE).

Test Plan:
- Reset, then req=0001, A=3, B=4, op=0 → gnt=0001 one cycle later; result=8'd7 and done=0001 for exactly one cycle; err=0; busy high for 2 cycles.
- req=1111 held, re-asserted after each done, all op=2 with operands A=i+1, B=2 → grant order 0,1,2,3,0. Results 2,4,6,8; each done one-hot and matching the granted requester.
- Requester 2: op=3, A=9, B=0 → result=8'hFF, err=1 with done=0100. Next request op=3, A=9, B=2 → result=8'd4, err=0.
- Requester 1: op=7, A=4'hA, B=4'h5, and req_a changed to 4'h0 during EXEC → result=8'hA5, since operands are latched at grant.
- Assert rst during EXEC of a grant to requester 3 → gnt, done, result, busy all 0 immediately. After release with req=1000 still high, requester 3 is regranted and completes normally.
- Requester 0 drops req during EXEC → done=0001 is still pulsed; no spurious second grant follows.
